// File: rtl/csd2bin_pipe.sv
// Pipelined CSD-to-binary converter with valid/ready flow control.
// Each stage decodes one chunk of digits and adds it into a running signed sum.
module csd2bin_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       y,
    output logic             ovf,
    output logic             err
);
    localparam int C = (W + STAGES - 1) / STAGES;

    // Chain between stages: index k is the input of stage k, index STAGES the output.
    logic [STAGES:0][W:0]         sum_c;
    logic [STAGES:0]              err_c;
    logic [STAGES:0]              vld_c;
    logic [STAGES-1:0][2*W-1:0]   dig_c;
    logic                         adv;

    // Single global stall: the whole pipe moves only when the output slot can drain.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign sum_c[0] = '0;
    assign err_c[0] = 1'b0;
    assign vld_c[0] = in_valid;
    assign dig_c[0] = x;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = (k * C < W) ? k * C : W;
        localparam int HI = ((k + 1) * C < W) ? (k + 1) * C : W;

        logic [W:0] sum_d, sum_q;
        logic       err_d, err_q;
        logic       vld_q;

        always_comb begin
            sum_d = sum_c[k];
            err_d = err_c[k];
            for (int i = LO; i < HI; i++) begin
                case (dig_c[k][2*i +: 2])
                    2'b01:   sum_d = sum_d + ((W+1)'(1) << i);
                    2'b10:   sum_d = sum_d - ((W+1)'(1) << i);
                    2'b11:   err_d = 1'b1;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q <= '0;
                err_q <= 1'b0;
                vld_q <= 1'b0;
            end else if (adv) begin
                sum_q <= sum_d;
                err_q <= err_d;
                vld_q <= vld_c[k];
            end
        end

        assign sum_c[k+1] = sum_q;
        assign err_c[k+1] = err_q;
        assign vld_c[k+1] = vld_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [2*W-1:0] dig_q;
            always_ff @(posedge clk) begin
                if (rst)      dig_q <= '0;
                else if (adv) dig_q <= dig_c[k];
            end
            assign dig_c[k+1] = dig_q;
        end else begin : g_last
            // Overflow is judged on the final sum and registered alongside y.
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (rst)      ovf_q <= 1'b0;
                else if (adv) ovf_q <= sum_d[W] ^ sum_d[W-1];
            end
            assign ovf = ovf_q;
        end
    end

    assign y         = sum_c[STAGES];
    assign err       = err_c[STAGES];
    assign out_valid = vld_c[STAGES];

endmodule

// File: tb/tb_csd2bin_pipe.sv
// Bench for csd2bin_pipe: directed vectors, backpressure, reset flush, and
// randomized streaming on three parameter sets against an arithmetic model.
module tb_csd2bin_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: W=8 STAGES=2
    logic        iv0 = 1'b0, ir0, ov0, or0 = 1'b1, of0, er0;
    logic [15:0] x0 = '0;
    logic [8:0]  y0;
    // Instance 1: W=5 STAGES=1
    logic        iv1 = 1'b0, ir1, ov1, or1 = 1'b1, of1, er1;
    logic [9:0]  x1 = '0;
    logic [5:0]  y1;
    // Instance 2: W=5 STAGES=5
    logic        iv2 = 1'b0, ir2, ov2, or2 = 1'b1, of2, er2;
    logic [9:0]  x2 = '0;
    logic [5:0]  y2;

    csd2bin_pipe #(.W(8), .STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .x(x0),
        .out_valid(ov0), .out_ready(or0), .y(y0), .ovf(of0), .err(er0));
    csd2bin_pipe #(.W(5), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .x(x1),
        .out_valid(ov1), .out_ready(or1), .y(y1), .ovf(of1), .err(er1));
    csd2bin_pipe #(.W(5), .STAGES(5)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .x(x2),
        .out_valid(ov2), .out_ready(or2), .y(y2), .ovf(of2), .err(er2));

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: value = sum(d_i * 2^i) as a plain integer, then range-checked.
    function automatic void model(input logic [15:0] xx, input int w,
                                  output logic [8:0] ey, output logic eo, output logic ee);
        int val;
        val = 0;
        ee  = 1'b0;
        for (int i = 0; i < w; i++) begin
            case (xx[2*i +: 2])
                2'b01:   val += (1 << i);
                2'b10:   val -= (1 << i);
                2'b11:   ee = 1'b1;
                default: ;
            endcase
        end
        eo = (val > (1 << (w-1)) - 1) || (val < -(1 << (w-1)));
        ey = 9'(val & ((1 << (w+1)) - 1));
    endfunction

    function automatic logic [15:0] rand_csd(input int w);
        logic [15:0] r;
        int          p;
        r = '0;
        for (int i = 0; i < w; i++) begin
            p = $urandom_range(0, 15);
            r[2*i +: 2] = (p < 6) ? 2'b00 : (p < 11) ? 2'b01 : (p < 15) ? 2'b10 : 2'b11;
        end
        return r;
    endfunction

    task automatic set_in(input int id, input logic v, input logic [15:0] xx, input logic r);
        case (id)
            0:       begin iv0 = v; x0 = xx;       or0 = r; end
            1:       begin iv1 = v; x1 = xx[9:0];  or1 = r; end
            default: begin iv2 = v; x2 = xx[9:0];  or2 = r; end
        endcase
    endtask

    task automatic get_out(input int id, output logic ir, output logic ov,
                           output logic [8:0] yy, output logic of, output logic er);
        case (id)
            0:       begin ir = ir0; ov = ov0; yy = y0;          of = of0; er = er0; end
            1:       begin ir = ir1; ov = ov1; yy = {3'b0, y1};  of = of1; er = er1; end
            default: begin ir = ir2; ov = ov2; yy = {3'b0, y2};  of = of2; er = er2; end
        endcase
    endtask

    // One word through instance 0 with out_ready high; checks latency and result.
    task automatic conv8(input string tag, input logic [15:0] xx,
                         input logic [8:0] ey, input logic eo, input logic ee);
        int lat;
        @(negedge clk);
        iv0 = 1'b1; x0 = xx; or0 = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(ir0), 32'd1);
        @(negedge clk);
        iv0 = 1'b0;
        #1;
        lat = 0;
        while (!ov0 && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd1);
        check({tag, ".y"},   32'(y0),  32'(ey));
        check({tag, ".ovf"}, 32'(of0), 32'(eo));
        check({tag, ".err"}, 32'(er0), 32'(ee));
    endtask

    task automatic run_random(input int id, input int w, input int n);
        logic [8:0]  qy[$];
        logic        qo[$], qe[$];
        logic [15:0] xx;
        logic [8:0]  ey, yy, py;
        logic        eo, ee, ir, ov, of, er, v, r, po, pe, stall;
        int          pushed, popped, cyc;
        string       tg;
        pushed = 0; popped = 0; cyc = 0; stall = 1'b0;
        py = '0; po = 1'b0; pe = 1'b0;
        while (popped < n && cyc < 10000) begin
            @(negedge clk);
            v  = (pushed < n) && ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 3) != 0);
            xx = rand_csd(w);
            set_in(id, v, xx, r);
            #1;
            get_out(id, ir, ov, yy, of, er);
            tg = $sformatf("rnd%0d", id);
            if (stall) begin
                check({tg, ".hold_vld"}, 32'(ov), 32'd1);
                check({tg, ".hold_y"},   32'(yy), 32'(py));
                check({tg, ".hold_oe"},  32'({of, er}), 32'({po, pe}));
            end
            if (ov && r) begin
                if (qy.size() == 0) begin
                    check({tg, ".spurious"}, 32'd1, 32'd0);
                end else begin
                    ey = qy.pop_front(); eo = qo.pop_front(); ee = qe.pop_front();
                    check($sformatf("%s.y[%0d]", tg, popped),   32'(yy), 32'(ey));
                    check($sformatf("%s.ovf[%0d]", tg, popped), 32'(of), 32'(eo));
                    check($sformatf("%s.err[%0d]", tg, popped), 32'(er), 32'(ee));
                end
                popped++;
            end
            if (v && ir) begin
                model(xx, w, ey, eo, ee);
                qy.push_back(ey); qo.push_back(eo); qe.push_back(ee);
                pushed++;
            end
            stall = ov && !r;
            py = yy; po = of; pe = er;
            cyc++;
        end
        check($sformatf("rnd%0d.completed", id), 32'(popped), 32'(n));
        set_in(id, 1'b0, 16'h0, 1'b1);
    endtask

    logic [15:0] bw [4] = '{16'h0001, 16'h0004, 16'h0005, 16'h0010};
    logic [8:0]  got [4];
    logic [8:0]  yhold;
    logic        have;
    int          acc, popped;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.out_valid", 32'(ov0), 32'd0);
        check("rst.y",         32'(y0),  32'd0);
        check("rst.ovf",       32'(of0), 32'd0);
        check("rst.err",       32'(er0), 32'd0);
        check("rst.in_ready",  32'(ir0), 32'd1);

        // Directed conversions
        conv8("v4002", 16'h4002, 9'h07F, 1'b0, 1'b0);
        conv8("v4000", 16'h4000, 9'h080, 1'b1, 1'b0);
        conv8("vAAAA", 16'hAAAA, 9'h101, 1'b1, 1'b0);
        conv8("v8000", 16'h8000, 9'h180, 1'b0, 1'b0);
        conv8("v00C0", 16'h00C0, 9'h000, 1'b0, 1'b1);
        conv8("v0001", 16'h0001, 9'h001, 1'b0, 1'b0);
        conv8("v0000", 16'h0000, 9'h000, 1'b0, 1'b0);
        conv8("vFFFF", 16'hFFFF, 9'h000, 1'b0, 1'b1);

        // Backpressure: capacity, hold stability, ordered drain
        @(negedge clk);
        or0 = 1'b0; acc = 0; have = 1'b0; yhold = '0;
        for (int c = 0; c < 6; c++) begin
            iv0 = 1'b1; x0 = bw[acc < 4 ? acc : 3];
            #1;
            if (ov0) begin
                if (!have) begin yhold = y0; have = 1'b1; end
                else check("bp.stable", 32'(y0), 32'(yhold));
            end
            if (ir0) acc++;
            @(negedge clk);
        end
        check("bp.accepted", 32'(acc), 32'd2);
        check("bp.in_ready_low", 32'(ir0), 32'd0);
        check("bp.first_y", 32'(yhold), 32'd1);
        popped = 0;
        for (int c = 0; c < 20 && popped < 4; c++) begin
            or0 = 1'b1;
            iv0 = (acc < 4);
            x0  = bw[acc < 4 ? acc : 3];
            #1;
            if (ov0) begin got[popped] = y0; popped++; end
            if (iv0 && ir0) acc++;
            @(negedge clk);
        end
        iv0 = 1'b0;
        check("bp.popped", 32'(popped), 32'd4);
        for (int j = 0; j < 4; j++) check($sformatf("bp.order[%0d]", j), 32'(got[j]), 32'(j + 1));

        // Reset with two words in flight
        @(negedge clk);
        or0 = 1'b0; iv0 = 1'b1; x0 = 16'h0001;
        @(negedge clk);
        x0 = 16'h0005;
        @(negedge clk);
        iv0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid.out_valid", 32'(ov0), 32'd0);
        check("rstmid.y",         32'(y0),  32'd0);
        rst = 1'b0; or0 = 1'b1;
        conv8("rstmid.new", 16'h0004, 9'h002, 1'b0, 1'b0);

        // Random streaming on all three configurations
        run_random(0, 8, 1000);
        run_random(1, 5, 1000);
        run_random(2, 5, 1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
